csr_commit_ctrl: RTL and testbench

Write-back-stage commit controller that drives the CSR register file from the pipeline side. It holds the WB instruction register and issues CSR reads and writes for csrrd, csrwr and csrxchg. It reports exceptions, interrupts and ertn to the CSR file, and generates the pipeline flush and redirect target toward fetch. It sits between the MEM stage and both the CSR file and the GPR file.

---
 rtl/csr_commit_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_csr_commit_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_commit_ctrl.sv
// Write-back commit controller: holds the WB instruction, drives CSR/GPR write ports,
// reports exceptions/ertn to the CSR file and redirects fetch after state-changing commits.
module csr_commit_ctrl (
  input  logic        clk,
  input  logic        resetn,
  // MEM -> WB handshake and payload
  input  logic        ms_valid,
  output logic        ms_ready,
  input  logic [31:0] ms_pc,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wvalue,
  input  logic [31:0] ms_csr_mask,
  input  logic        ms_ertn,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic [31:0] ms_vaddr,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_result,
  // CSR file port
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  // exception / ertn reporting
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_vaddr,
  output logic [31:0] wb_pc,
  // GPR write port
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  // fetch redirect
  output logic        flush,
  output logic [31:0] flush_target
);

  localparam logic [1:0] OpNone   = 2'b00;
  localparam logic [1:0] OpCsrwr  = 2'b10;
  localparam logic [1:0] OpCsrxch = 2'b11;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_target_q, flush_target_d;

  logic        ws_valid_q, ws_valid_d;
  logic [31:0] ws_pc_q, ws_pc_d;
  logic [1:0]  ws_csr_op_q, ws_csr_op_d;
  logic [13:0] ws_csr_num_q, ws_csr_num_d;
  logic [31:0] ws_csr_wvalue_q, ws_csr_wvalue_d;
  logic [31:0] ws_csr_mask_q, ws_csr_mask_d;
  logic        ws_ertn_q, ws_ertn_d;
  logic        ws_ex_q, ws_ex_d;
  logic [5:0]  ws_ecode_q, ws_ecode_d;
  logic [8:0]  ws_esubcode_q, ws_esubcode_d;
  logic [31:0] ws_vaddr_q, ws_vaddr_d;
  logic        ws_rf_we_q, ws_rf_we_d;
  logic [4:0]  ws_rf_waddr_q, ws_rf_waddr_d;
  logic [31:0] ws_result_q, ws_result_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        accept;

  // Both states take whatever MEM offers; FLUSH simply discards it.
  assign ms_ready     = 1'b1;
  assign flush        = flush_q;
  assign flush_target = flush_target_q;

  // Commit decode: purely combinational from the WB register.
  always_comb begin
    csr_re          = 1'b0;
    csr_we          = 1'b0;
    csr_num         = 14'd0;
    csr_wmask       = 32'd0;
    csr_wvalue      = 32'd0;
    wb_ex           = 1'b0;
    ertn_flush      = 1'b0;
    wb_ecode        = 6'd0;
    wb_esubcode     = 9'd0;
    wb_vaddr        = 32'd0;
    wb_pc           = 32'd0;
    rf_we           = 1'b0;
    rf_waddr        = 5'd0;
    rf_wdata        = 32'd0;
    redirect        = 1'b0;
    redirect_target = 32'd0;

    if (ws_valid_q) begin
      wb_pc = ws_pc_q;
      if (ws_ex_q) begin
        // Exception suppresses every architectural side effect, ertn included.
        wb_ex           = 1'b1;
        wb_ecode        = ws_ecode_q;
        wb_esubcode     = ws_esubcode_q;
        wb_vaddr        = ws_vaddr_q;
        redirect        = 1'b1;
        redirect_target = ex_entry;
      end else if (ws_ertn_q) begin
        ertn_flush      = 1'b1;
        redirect        = 1'b1;
        redirect_target = ertn_entry;
      end else if (ws_csr_op_q != OpNone) begin
        csr_re   = 1'b1;
        csr_num  = ws_csr_num_q;
        rf_we    = ws_rf_we_q;
        rf_waddr = ws_rf_waddr_q;
        rf_wdata = csr_rvalue;
        if (ws_csr_op_q == OpCsrwr || ws_csr_op_q == OpCsrxch) begin
          csr_we     = 1'b1;
          csr_wmask  = (ws_csr_op_q == OpCsrxch) ? ws_csr_mask_q : 32'hFFFF_FFFF;
          csr_wvalue = ws_csr_wvalue_q;
          // Refetch so younger instructions observe the new CSR state.
          redirect        = 1'b1;
          redirect_target = ws_pc_q + 32'd4;
        end
      end else begin
        rf_we    = ws_rf_we_q;
        rf_waddr = ws_rf_waddr_q;
        rf_wdata = ws_result_q;
      end
    end
  end

  // Next-state: FSM, WB register and registered redirect outputs.
  always_comb begin
    state_d         = state_q;
    flush_d         = 1'b0;
    flush_target_d  = flush_target_q;
    ws_valid_d      = 1'b0;
    accept          = 1'b0;

    ws_pc_d         = ws_pc_q;
    ws_csr_op_d     = ws_csr_op_q;
    ws_csr_num_d    = ws_csr_num_q;
    ws_csr_wvalue_d = ws_csr_wvalue_q;
    ws_csr_mask_d   = ws_csr_mask_q;
    ws_ertn_d       = ws_ertn_q;
    ws_ex_d         = ws_ex_q;
    ws_ecode_d      = ws_ecode_q;
    ws_esubcode_d   = ws_esubcode_q;
    ws_vaddr_d      = ws_vaddr_q;
    ws_rf_we_d      = ws_rf_we_q;
    ws_rf_waddr_d   = ws_rf_waddr_q;
    ws_result_d     = ws_result_q;

    unique case (state_q)
      StRun: begin
        if (redirect) begin
          state_d        = StFlush;
          flush_d        = 1'b1;
          flush_target_d = redirect_target;
        end else if (ms_valid) begin
          accept = 1'b1;
        end
      end
      StFlush: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (accept) begin
      ws_valid_d      = 1'b1;
      ws_pc_d         = ms_pc;
      ws_csr_op_d     = ms_csr_op;
      ws_csr_num_d    = ms_csr_num;
      ws_csr_wvalue_d = ms_csr_wvalue;
      ws_csr_mask_d   = ms_csr_mask;
      ws_ertn_d       = ms_ertn;
      ws_vaddr_d      = ms_vaddr;
      ws_rf_we_d      = ms_rf_we;
      ws_rf_waddr_d   = ms_rf_waddr;
      ws_result_d     = ms_result;
      // An upstream exception takes priority over a pending interrupt.
      if (!ms_ex && has_int) begin
        ws_ex_d       = 1'b1;
        ws_ecode_d    = 6'h00;
        ws_esubcode_d = 9'd0;
      end else begin
        ws_ex_d       = ms_ex;
        ws_ecode_d    = ms_ecode;
        ws_esubcode_d = ms_esubcode;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StRun;
      flush_q         <= 1'b0;
      flush_target_q  <= 32'd0;
      ws_valid_q      <= 1'b0;
      ws_pc_q         <= 32'd0;
      ws_csr_op_q     <= 2'd0;
      ws_csr_num_q    <= 14'd0;
      ws_csr_wvalue_q <= 32'd0;
      ws_csr_mask_q   <= 32'd0;
      ws_ertn_q       <= 1'b0;
      ws_ex_q         <= 1'b0;
      ws_ecode_q      <= 6'd0;
      ws_esubcode_q   <= 9'd0;
      ws_vaddr_q      <= 32'd0;
      ws_rf_we_q      <= 1'b0;
      ws_rf_waddr_q   <= 5'd0;
      ws_result_q     <= 32'd0;
    end else begin
      state_q         <= state_d;
      flush_q         <= flush_d;
      flush_target_q  <= flush_target_d;
      ws_valid_q      <= ws_valid_d;
      ws_pc_q         <= ws_pc_d;
      ws_csr_op_q     <= ws_csr_op_d;
      ws_csr_num_q    <= ws_csr_num_d;
      ws_csr_wvalue_q <= ws_csr_wvalue_d;
      ws_csr_mask_q   <= ws_csr_mask_d;
      ws_ertn_q       <= ws_ertn_d;
      ws_ex_q         <= ws_ex_d;
      ws_ecode_q      <= ws_ecode_d;
      ws_esubcode_q   <= ws_esubcode_d;
      ws_vaddr_q      <= ws_vaddr_d;
      ws_rf_we_q      <= ws_rf_we_d;
      ws_rf_waddr_q   <= ws_rf_waddr_d;
      ws_result_q     <= ws_result_d;
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Bench for csr_commit_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the WB slot, the one-cycle flush bubble and a small CSR file.
module tb_csr_commit_ctrl;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] wv;
    logic [31:0] mask;
    logic        ertn;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
  } stim_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_valid, ms_ready;
  logic [31:0] ms_pc, ms_csr_wvalue, ms_csr_mask, ms_vaddr, ms_result;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic        ms_ertn, ms_ex, ms_rf_we;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic [4:0]  ms_rf_waddr;
  logic        csr_re, csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
  logic        has_int;
  logic [31:0] ex_entry, ertn_entry;
  logic        wb_ex, ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_vaddr, wb_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush;
  logic [31:0] flush_target;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: CSR file (indexed by low CSR bits), WB slot, pending flush.
  logic [31:0] csr_file [16];
  logic        m_valid;
  stim_t       m;
  logic        m_flush;
  logic [31:0] m_target;
  logic [31:0] g_ex_entry   = 32'h1C00_8000;
  logic [31:0] g_ertn_entry = 32'h1C00_0200;

  assign csr_rvalue = csr_file[csr_num[3:0]];

  always #5 clk = ~clk;

  csr_commit_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ms_valid(ms_valid), .ms_ready(ms_ready), .ms_pc(ms_pc),
    .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
    .ms_csr_wvalue(ms_csr_wvalue), .ms_csr_mask(ms_csr_mask),
    .ms_ertn(ms_ertn), .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
    .ms_vaddr(ms_vaddr), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_result(ms_result),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .wb_pc(wb_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .flush_target(flush_target)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic stim_t mk_idle();
    stim_t s;
    s            = '0;
    s.ex_entry   = g_ex_entry;
    s.ertn_entry = g_ertn_entry;
    return s;
  endfunction

  function automatic stim_t mk_rand();
    stim_t s;
    s.valid      = ($urandom_range(0, 9) < 7);
    s.pc         = $urandom;
    s.op         = 2'($urandom_range(0, 3));
    s.num        = 14'($urandom);
    s.wv         = $urandom;
    s.mask       = $urandom;
    s.ertn       = ($urandom_range(0, 9) == 0);
    s.ex         = ($urandom_range(0, 9) == 0);
    s.ecode      = 6'($urandom);
    s.esub       = 9'($urandom);
    s.vaddr      = $urandom;
    s.rf_we      = 1'($urandom);
    s.waddr      = 5'($urandom);
    s.result     = $urandom;
    s.has_int    = ($urandom_range(0, 11) == 0);
    s.ex_entry   = $urandom;
    s.ertn_entry = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ms_valid      = s.valid;
    ms_pc         = s.pc;
    ms_csr_op     = s.op;
    ms_csr_num    = s.num;
    ms_csr_wvalue = s.wv;
    ms_csr_mask   = s.mask;
    ms_ertn       = s.ertn;
    ms_ex         = s.ex;
    ms_ecode      = s.ecode;
    ms_esubcode   = s.esub;
    ms_vaddr      = s.vaddr;
    ms_rf_we      = s.rf_we;
    ms_rf_waddr   = s.waddr;
    ms_result     = s.result;
    has_int       = s.has_int;
    ex_entry      = s.ex_entry;
    ertn_entry    = s.ertn_entry;
  endtask

  // Compare every output of the current cycle against the reference.
  task automatic check_cycle();
    logic is_csr, is_wr;
    check_eq("ms_ready", 32'(ms_ready), 32'd1);
    check_eq("flush", 32'(flush), 32'(m_flush));
    if (m_flush) check_eq("flush_target", flush_target, m_target);
    if (!m_valid) begin
      check_eq("idle_csr_re", 32'(csr_re), 0);
      check_eq("idle_csr_we", 32'(csr_we), 0);
      check_eq("idle_csr_num", 32'(csr_num), 0);
      check_eq("idle_csr_wmask", csr_wmask, 0);
      check_eq("idle_csr_wvalue", csr_wvalue, 0);
      check_eq("idle_wb_ex", 32'(wb_ex), 0);
      check_eq("idle_ertn_flush", 32'(ertn_flush), 0);
      check_eq("idle_wb_ecode", 32'(wb_ecode), 0);
      check_eq("idle_wb_esubcode", 32'(wb_esubcode), 0);
      check_eq("idle_wb_vaddr", wb_vaddr, 0);
      check_eq("idle_wb_pc", wb_pc, 0);
      check_eq("idle_rf_we", 32'(rf_we), 0);
      check_eq("idle_rf_waddr", 32'(rf_waddr), 0);
      check_eq("idle_rf_wdata", rf_wdata, 0);
    end else begin
      is_csr = !m.ex && !m.ertn && (m.op != 2'b00);
      is_wr  = is_csr && (m.op == 2'b10 || m.op == 2'b11);
      check_eq("wb_ex", 32'(wb_ex), 32'(m.ex));
      check_eq("ertn_flush", 32'(ertn_flush), 32'(!m.ex && m.ertn));
      check_eq("csr_re", 32'(csr_re), 32'(is_csr));
      check_eq("csr_we", 32'(csr_we), 32'(is_wr));
      check_eq("rf_we", 32'(rf_we), 32'(!m.ex && !m.ertn && m.rf_we));
      if (m.ex) begin
        check_eq("wb_ecode", 32'(wb_ecode), 32'(m.ecode));
        check_eq("wb_esubcode", 32'(wb_esubcode), 32'(m.esub));
        check_eq("wb_vaddr", wb_vaddr, m.vaddr);
        check_eq("wb_pc", wb_pc, m.pc);
      end
      if (is_csr) check_eq("csr_num", 32'(csr_num), 32'(m.num));
      if (is_wr) begin
        check_eq("csr_wmask", csr_wmask, (m.op == 2'b11) ? m.mask : 32'hFFFF_FFFF);
        check_eq("csr_wvalue", csr_wvalue, m.wv);
      end
      if (!m.ex && !m.ertn && m.rf_we) begin
        check_eq("rf_waddr", 32'(rf_waddr), 32'(m.waddr));
        check_eq("rf_wdata", rf_wdata, is_csr ? csr_file[m.num[3:0]] : m.result);
      end
    end
  endtask

  // One cycle: check at the falling edge, drive s, advance the reference at the rising edge.
  task automatic step(input stim_t s);
    logic        redir, was_flush;
    logic [31:0] tgt, wmask;
    @(negedge clk);
    check_cycle();
    drive(s);
    redir = m_valid && (m.ex || m.ertn || m.op == 2'b10 || m.op == 2'b11);
    tgt   = m.ex ? s.ex_entry : (m.ertn ? s.ertn_entry : m.pc + 32'd4);
    @(posedge clk);
    if (m_valid && !m.ex && !m.ertn && (m.op == 2'b10 || m.op == 2'b11)) begin
      wmask = (m.op == 2'b11) ? m.mask : 32'hFFFF_FFFF;
      csr_file[m.num[3:0]] = (csr_file[m.num[3:0]] & ~wmask) | (m.wv & wmask);
    end
    was_flush = m_flush;
    m_flush   = redir;
    if (redir) m_target = tgt;
    if (redir || was_flush || !s.valid) begin
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      m       = s;
      if (s.has_int && !s.ex) begin
        m.ex    = 1'b1;
        m.ecode = 6'h00;
        m.esub  = 9'd0;
      end
    end
  endtask

  initial begin
    stim_t s;
    for (int i = 0; i < 16; i++) csr_file[i] = $urandom;
    csr_file[0] = 32'h8;
    csr_file[4] = 32'h0;
    m_valid  = 1'b0;
    m        = '0;
    m_flush  = 1'b0;
    m_target = 32'd0;
    resetn   = 1'b0;
    drive(mk_idle());
    #23;
    check_cycle();
    check_eq("reset_flush_target", flush_target, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step(mk_idle());

    // csrwr CRMD
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0100; s.op = 2'b10; s.num = 14'h0;
    s.wv = 32'h4; s.rf_we = 1; s.waddr = 5'd5;
    step(s);
    #1;
    check_eq("crmd_csr_we", 32'(csr_we), 1);
    check_eq("crmd_wmask", csr_wmask, 32'hFFFF_FFFF);
    check_eq("crmd_rf_wdata", rf_wdata, 32'h8);
    check_eq("crmd_rf_we", 32'(rf_we), 1);
    step(mk_idle());
    #1;
    check_eq("crmd_flush", 32'(flush), 1);
    check_eq("crmd_target", flush_target, 32'h1C00_0104);
    step(mk_idle());

    // csrxchg ECFG, younger instruction offered during the commit cycle
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0300; s.op = 2'b11; s.num = 14'h4;
    s.wv = 32'hFFF; s.mask = 32'h800; s.rf_we = 1; s.waddr = 5'd7;
    step(s);
    #1;
    check_eq("xchg_wmask", csr_wmask, 32'h800);
    check_eq("xchg_wvalue", csr_wvalue, 32'hFFF);
    check_eq("xchg_rf_wdata", rf_wdata, 32'h0);
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0304; s.rf_we = 1; s.waddr = 5'd9;
    s.result = 32'hDEAD;
    step(s);
    #1;
    check_eq("xchg_flush", 32'(flush), 1);
    check_eq("xchg_dropped", 32'(rf_we), 0);
    step(mk_idle());

    // Upstream ALE
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0400; s.ex = 1; s.ecode = 6'h09;
    s.vaddr = 32'h1003; s.rf_we = 1; s.op = 2'b10;
    step(s);
    #1;
    check_eq("ale_wb_ex", 32'(wb_ex), 1);
    check_eq("ale_wb_vaddr", wb_vaddr, 32'h1003);
    check_eq("ale_rf_we", 32'(rf_we), 0);
    check_eq("ale_csr_we", 32'(csr_we), 0);
    step(mk_idle());
    #1;
    check_eq("ale_target", flush_target, 32'h1C00_8000);
    step(mk_idle());

    // Interrupt tagged onto an add
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0500; s.rf_we = 1; s.waddr = 5'd3;
    s.result = 32'h55; s.has_int = 1;
    step(s);
    #1;
    check_eq("int_wb_ex", 32'(wb_ex), 1);
    check_eq("int_ecode", 32'(wb_ecode), 0);
    check_eq("int_rf_we", 32'(rf_we), 0);
    step(mk_idle());
    #1;
    check_eq("int_target", flush_target, g_ex_entry);
    step(mk_idle());

    // ertn with back-to-back younger traffic
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0600; s.ertn = 1;
    step(s);
    #1;
    check_eq("ertn_flush", 32'(ertn_flush), 1);
    check_eq("ertn_wb_ex", 32'(wb_ex), 0);
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0604; s.rf_we = 1; s.waddr = 5'd4;
    step(s);
    #1;
    check_eq("ertn_flush_next", 32'(flush), 1);
    check_eq("ertn_target", flush_target, 32'h1C00_0200);
    s.pc = 32'h1C00_0608;
    step(s);
    #1;
    check_eq("ertn_drop2", 32'(rf_we), 0);
    step(mk_idle());

    // Reset asserted while in FLUSH
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0700; s.op = 2'b10; s.num = 14'h2;
    step(s);
    step(mk_idle());
    #1;
    check_eq("rst_pre_flush", 32'(flush), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_flush", 32'(flush), 0);
    check_eq("rst_target", flush_target, 0);
    check_eq("rst_csr_we", 32'(csr_we), 0);
    check_eq("rst_rf_we", 32'(rf_we), 0);
    check_eq("rst_wb_ex", 32'(wb_ex), 0);
    m_valid  = 1'b0;
    m_flush  = 1'b0;
    m_target = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    s = mk_idle(); s.valid = 1; s.pc = 32'h1C00_0800; s.rf_we = 1; s.waddr = 5'd1;
    s.result = 32'h1234;
    step(s);
    #1;
    check_eq("post_rst_rf_we", 32'(rf_we), 1);
    check_eq("post_rst_rf_wdata", rf_wdata, 32'h1234);

    // Random traffic
    for (int i = 0; i < 3000; i++) step(mk_rand());
    step(mk_idle());
    step(mk_idle());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
